// File: rtl/clock_ratio_checker.sv
// Samples a divided clock as data in the clock_in domain, measures its period
// and tracks lock/fault. Optional duty check is enabled by DUTY_CHECK_EN.
module clock_ratio_checker #(
  parameter int DIV        = 4,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             clock_slow,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             error,
  output logic [7:0]       err_count
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam int GW  = $clog2(LOCK_COUNT + 1);
  localparam int PLO = DIV - TOL;
  localparam int PHI = DIV + TOL;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(2 * DIV + TOL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED,
    S_FAULT
  } state_t;

  state_t           r_state, w_nstate;
  logic             r_s1, r_s2, r_s3;
  logic             r_rise, r_fall;
  logic             r_pvalid, r_locked, r_error;
  logic [CNT_W-1:0] r_cnt, r_period;
  logic [GW-1:0]    r_good_cnt, w_ngood, w_ginc;
  logic [7:0]       r_err_cnt;
  logic             w_err_inc, w_pgood, w_good, w_tmo;
  logic signed [31:0] w_cnt_s;

  assign w_cnt_s = $signed(32'(r_cnt));
  assign w_pgood = (w_cnt_s >= PLO) && (w_cnt_s <= PHI);
  assign w_ginc  = r_good_cnt + GW'(1);
  // A rise in the timeout cycle wins over the timeout.
  assign w_tmo   = (r_state != S_IDLE) && (r_cnt == TMO) && !r_rise;

`ifdef DUTY_CHECK_EN
  localparam int HLO = DIV / 2 - TOL;
  localparam int HHI = (DIV + 1) / 2 + TOL;
  logic [CNT_W-1:0]   r_high_time;
  logic               r_duty_err;
  logic signed [31:0] w_hi_s;
  logic               w_dgood;

  assign w_hi_s   = $signed(32'(r_high_time));
  assign w_dgood  = (w_hi_s >= HLO) && (w_hi_s <= HHI);
  assign w_good   = w_pgood && w_dgood;
  assign duty_err = r_duty_err;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      r_high_time <= '0;
      r_duty_err  <= 1'b0;
    end else begin
      if (r_fall) r_high_time <= r_cnt;
      r_duty_err <= r_rise && w_pgood && !w_dgood &&
                    (r_state == S_ACQ || r_state == S_LOCKED);
    end
  end
`else
  assign w_good = w_pgood;
`endif

  always_comb begin
    w_nstate  = r_state;
    w_ngood   = r_good_cnt;
    w_err_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_rise) begin
          w_nstate = S_ACQ;
          w_ngood  = '0;
        end
      end
      S_ACQ: begin
        if (r_rise && w_good) begin
          if (w_ginc == GW'(LOCK_COUNT)) begin
            w_nstate = S_LOCKED;
            w_ngood  = '0;
          end else begin
            w_ngood = w_ginc;
          end
        end else if (r_rise) begin
          w_ngood = '0;
        end else if (w_tmo) begin
          w_nstate = S_IDLE;
          w_ngood  = '0;
        end
      end
      S_LOCKED: begin
        if ((r_rise && !w_good) || w_tmo) begin
          w_nstate  = S_FAULT;
          w_err_inc = 1'b1;
        end
      end
      S_FAULT: begin
        if (r_rise) begin
          w_nstate = S_ACQ;
          w_ngood  = '0;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_cnt      <= '0;
      r_period   <= '0;
      r_pvalid   <= 1'b0;
      r_state    <= S_IDLE;
      r_good_cnt <= '0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_s1   <= clock_slow;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
      if (r_rise) r_cnt <= CNT_W'(1);
      else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      r_pvalid <= r_rise && (r_state != S_IDLE);
      if (r_rise && (r_state != S_IDLE)) r_period <= r_cnt;
      r_state    <= w_nstate;
      r_good_cnt <= w_ngood;
      r_locked   <= (w_nstate == S_LOCKED);
      r_error    <= (w_nstate == S_FAULT);
      if (w_err_inc && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign period       = r_period;
  assign period_valid = r_pvalid;
  assign locked       = r_locked;
  assign error        = r_error;
  assign err_count    = r_err_cnt;

endmodule

// File: doc/clock_ratio_checker.md
Name: clock_ratio_checker

Overview:
- Receiving end of the clock divider: consumes the divided clock as a data signal in the fast clock_in domain.
- Synchronises it and produces single-cycle edge pulses.
- Measures each period in clock_in cycles and checks it against the expected division ratio.
- Reports lock/fault status; the slow clock is never used as a clock inside this block.

Parameters:
DIV, 4, expected clock_in cycles per slow-clock period (>=2)
TOL, 0, allowed +/- deviation of measured period from DIV, in cycles
LOCK_COUNT, 3, consecutive in-tolerance periods required to assert locked (>=1)
CNT_W, 16, width of period counter and period output

Ports:
clock_in  in  1  fast system clock, rising-edge
rst  in  1  asynchronous active-high reset
clock_slow  in  1  divided clock under test, sampled as data
rise_pulse  out  1  one-cycle pulse per synchronised rising edge
fall_pulse  out  1  one-cycle pulse per synchronised falling edge
period  out  CNT_W  last measured period in clock_in cycles
period_valid  out  1  one-cycle strobe when period updates
locked  out  1  high in LOCKED state
error  out  1  high in FAULT state
err_count  out  8  saturating count of LOCKED->FAULT transitions

Behaviour:
- Reset (async, rst=1): sync flops, edge register, counter, good_cnt and all outputs = 0; state = IDLE. Asserting rst mid-operation clears everything immediately, with no wait for a clock.
- Sync: 2-flop synchroniser, then a delay flop.
  - rise_pulse = s2 & ~s3; fall_pulse = ~s2 & s3; both registered.
  - Pulse appears 3 clock_in edges after the clock_slow transition.
- Counter cnt:
  - On rise_pulse cycle: cnt <= 1.
  - Else: cnt <= cnt+1, saturating at all-ones.
- Measurement: on a rise_pulse cycle in any state except IDLE:
  - period <= cnt.
  - period_valid = 1 in the following cycle, for exactly one cycle.
- good = (period_meas >= DIV-TOL) && (period_meas <= DIV+TOL).
- Timeout: in ACQ, LOCKED or FAULT, when cnt == 2*DIV+TOL with no rise_pulse in that cycle.
- States:
  - IDLE: first rise_pulse -> ACQ. cnt starts; no period reported.
  - ACQ:
    - rise & good: good_cnt++; if good_cnt+1 == LOCK_COUNT -> LOCKED.
    - rise & !good: good_cnt <= 0, stay in ACQ.
    - timeout -> IDLE.
  - LOCKED:
    - rise & good: stay.
    - rise & !good, or timeout -> FAULT; err_count++ (saturates at 255).
  - FAULT:
    - Next rise_pulse -> ACQ with good_cnt <= 0; that period is not evaluated.
    - Timeouts while in FAULT do not re-increment err_count.
- Outputs: locked = (state==LOCKED) and error = (state==FAULT), both registered with the state.
- Simultaneous events: a rise_pulse in the same cycle as cnt hitting the timeout value counts as a rise, not a timeout.
- Period value and counter saturation:
  - period holds its last value until the next measurement; it is not cleared on FAULT.
  - A saturated cnt measured as period is simply !good.

Optional Feature:
- Macro DUTY_CHECK_EN.
- Defined:
  - Capture high_time = cnt value on each fall_pulse.
  - On rise, good additionally requires high_time within [floor(DIV/2)-TOL, ceil(DIV/2)+TOL].
  - Extra output duty_err (1 bit, reset 0): one-cycle pulse on a rise whose period passed but whose duty failed.
- Undefined: no high_time register, no duty_err port; good depends on period only.

Test Plan:
1. DIV=4, LOCK_COUNT=3. Run clock_slow with period 4 (toggle every 2 clock_in). Expect:
   - rise_pulse 3 cycles after each clock_slow rise.
   - period=4 with period_valid on each rise after the first.
   - locked=1 after the 3rd reported period; error=0, err_count=0.
2. Locked, then stretch one period to 6. Expect:
   - period=6; error=1, locked=0, err_count=1.
   - Resume period 4: ACQ on the next rise, then locked again after 3 good periods, err_count stays 1.
3. Locked, then hold clock_slow low. Expect:
   - FAULT exactly when cnt reaches 8; err_count=1.
   - Stays FAULT with no further increment.
   - Restart period-4 clock: relock after 3 good periods.
4. TOL=1, alternate periods 3 and 5. Expect locked=1 and no error. With TOL=0 the same stimulus never locks.
5. Assert rst asynchronously mid-LOCKED, between clock_in edges. Expect all outputs 0 immediately; after release, IDLE and relock from scratch.
6. DUTY_CHECK_EN defined, period 4 with high time 1. Expect duty_err pulse on each rise, no lock. High time 2: lock as in test 1.
